// File: rtl/tick_gen_pkg.sv
// Shared types and reset constants for the programmable tick generator.
// Channel modes, channel state encoding and the default period width.
package tick_gen_pkg;

  localparam int unsigned TICK_PERIOD_WIDTH   = 16;
  localparam int unsigned TICK_DEFAULT_PERIOD = 96;

  typedef logic [TICK_PERIOD_WIDTH-1:0] period_t;

  typedef enum logic {
    MODE_PERIODIC,
    MODE_ONE_SHOT
  } tick_mode_t;

  typedef enum logic {
    CH_IDLE,
    CH_RUN
  } ch_state_t;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: shadow period/mode, down-counter, run state.
// Shadow values only reach the counter at a load or periodic reload.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int unsigned PW    = TICK_PERIOD_WIDTH,
  parameter int unsigned DEF_P = TICK_DEFAULT_PERIOD
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_we_i,
  input  logic [PW-1:0] cfg_period_i,
  input  logic          cfg_one_shot_i,
  input  logic          start_i,
  input  logic          stop_i,
  output logic          tick_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [PW-1:0] ONE = PW'(1);

  ch_state_t     state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] shp_q, shp_d;
  tick_mode_t    shm_q, shm_d;
  tick_mode_t    mode_q, mode_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d;

  logic running;
  logic p_zero;
  logic load;
  logic expire;
  logic count;

  assign running = (state_q == CH_RUN);
  assign p_zero  = (shp_q == '0);
  // A start with a zero shadow period is dropped entirely.
  assign load    = start_i && !stop_i && !p_zero;
  assign expire  = running && !stop_i && !load
                && (cnt_q == '0);
  assign count   = running && !stop_i && !load
                && (cnt_q != '0);

  assign shp_d = cfg_we_i ? cfg_period_i : shp_q;
  assign shm_d = cfg_we_i ? tick_mode_t'(cfg_one_shot_i)
                          : shm_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      stop_i: state_d = CH_IDLE;
      load:   state_d = CH_RUN;
      expire: begin
        if (mode_q == MODE_ONE_SHOT || p_zero) begin
          state_d = CH_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    tick_d = 1'b0;
    done_d = 1'b0;
    unique case (1'b1)
      load: begin
        cnt_d  = shp_q - ONE;
        mode_d = shm_q;
      end
      expire: begin
        tick_d = 1'b1;
        if (mode_q == MODE_ONE_SHOT) begin
          done_d = 1'b1;
        end else begin
          cnt_d  = shp_q - ONE;
          mode_d = shm_q;
        end
      end
      count:  cnt_d = cnt_q - ONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      shp_q  <= PW'(DEF_P);
      shm_q  <= MODE_PERIODIC;
      mode_q <= MODE_PERIODIC;
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      shp_q  <= shp_d;
      shm_q  <= shm_d;
      mode_q <= mode_d;
      tick_q <= tick_d;
      done_q <= done_d;
    end
  end

  assign tick_o = tick_q;
  assign done_o = done_q;
  assign busy_o = running;

endmodule

// File: rtl/tick_pulse_gen.sv
// Runtime-programmable multi-channel tick generator.
// Decodes config writes and fans them out to independent channels.
module tick_pulse_gen
  import tick_gen_pkg::*;
#(
  parameter int unsigned NUM_OF_CHANNELS = 4,
  parameter int unsigned PERIOD_WIDTH    = TICK_PERIOD_WIDTH,
  parameter int unsigned DEFAULT_PERIOD  = TICK_DEFAULT_PERIOD,
  localparam int unsigned CHW =
    (NUM_OF_CHANNELS > 1) ? $clog2(NUM_OF_CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cfg_we,
  input  logic [CHW-1:0]             cfg_ch,
  input  logic [PERIOD_WIDTH-1:0]    cfg_period,
  input  logic                       cfg_one_shot,
  input  logic [NUM_OF_CHANNELS-1:0] start,
  input  logic [NUM_OF_CHANNELS-1:0] stop,
  input  logic                       sync_start,
  output logic [NUM_OF_CHANNELS-1:0] tick,
  output logic [NUM_OF_CHANNELS-1:0] busy,
  output logic [NUM_OF_CHANNELS-1:0] done
);

  logic [NUM_OF_CHANNELS-1:0] ch_we;
  logic [NUM_OF_CHANNELS-1:0] ch_start;

  assign ch_start = start | {NUM_OF_CHANNELS{sync_start}};

  for (genvar i = 0; i < NUM_OF_CHANNELS; i++) begin : g_ch
    // Out-of-range cfg_ch values match no channel and are dropped.
    assign ch_we[i] = cfg_we && (32'(cfg_ch) == i);

    tick_channel #(
      .PW    (PERIOD_WIDTH),
      .DEF_P (DEFAULT_PERIOD)
    ) u_ch (
      .clk            (clk),
      .reset_n        (reset_n),
      .cfg_we_i       (ch_we[i]),
      .cfg_period_i   (cfg_period),
      .cfg_one_shot_i (cfg_one_shot),
      .start_i        (ch_start[i]),
      .stop_i         (stop[i]),
      .tick_o         (tick[i]),
      .busy_o         (busy[i]),
      .done_o         (done[i])
    );
  end

endmodule

// File: tb/tb_tick_pulse_gen.sv
// Randomized and directed bench for tick_pulse_gen.
// Reference keeps absolute due-times per channel, not down-counters.
module tb_tick_pulse_gen;

  localparam int N    = 5;
  localparam int PW   = 16;
  localparam int DEFP = 96;
  localparam int CHW  = 3;

  logic          clk;
  logic          reset_n;
  logic          cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [PW-1:0] cfg_period;
  logic          cfg_one_shot;
  logic [N-1:0]  start;
  logic [N-1:0]  stop;
  logic          sync_start;
  logic [N-1:0]  tick;
  logic [N-1:0]  busy;
  logic [N-1:0]  done;

  tick_pulse_gen #(
    .NUM_OF_CHANNELS (N),
    .PERIOD_WIDTH    (PW),
    .DEFAULT_PERIOD  (DEFP)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_period   (cfg_period),
    .cfg_one_shot (cfg_one_shot),
    .start        (start),
    .stop         (stop),
    .sync_start   (sync_start),
    .tick         (tick),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  longint      now;
  bit          m_run [N];
  longint      m_due [N];
  int          m_shp [N];
  bit          m_shm [N];
  bit          m_act [N];
  logic [N-1:0] m_tick;
  logic [N-1:0] m_done;
  logic [N-1:0] m_busy;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_run[i] = 1'b0;
      m_due[i] = 0;
      m_shp[i] = DEFP;
      m_shm[i] = 1'b0;
      m_act[i] = 1'b0;
    end
    m_tick = '0;
    m_done = '0;
  endtask

  task automatic model_edge();
    bit st;
    for (int i = 0; i < N; i++) begin
      st = start[i] | sync_start;
      m_tick[i] = 1'b0;
      m_done[i] = 1'b0;
      if (stop[i]) begin
        m_run[i] = 1'b0;
      end else if (st && m_shp[i] != 0) begin
        m_run[i] = 1'b1;
        m_act[i] = m_shm[i];
        m_due[i] = now + m_shp[i];
      end else if (m_run[i] && now == m_due[i]) begin
        m_tick[i] = 1'b1;
        if (m_act[i]) begin
          m_run[i]  = 1'b0;
          m_done[i] = 1'b1;
        end else begin
          m_due[i] = now + m_shp[i];
          m_act[i] = m_shm[i];
        end
      end
    end
    if (cfg_we && int'(cfg_ch) < N) begin
      m_shp[cfg_ch] = int'(cfg_period);
      m_shm[cfg_ch] = cfg_one_shot;
    end
    now++;
  endtask

  task automatic tick_edge();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    #1;
    for (int i = 0; i < N; i++) m_busy[i] = m_run[i];
    check("tick", 32'(tick), 32'(m_tick));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    start      = '0;
    stop       = '0;
    sync_start = 1'b0;
    cfg_we     = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int p,
                           input bit os);
    cfg_we       = 1'b1;
    cfg_ch       = CHW'(ch);
    cfg_period   = PW'(p);
    cfg_one_shot = os;
    tick_edge();
  endtask

  task automatic wait_tick(input int ch, input int limit,
                           output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      tick_edge();
      if (tick[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  int n;
  int cnt0;
  int cnt3;

  initial begin
    reset_n      = 1'b0;
    cfg_we       = 1'b0;
    cfg_ch       = '0;
    cfg_period   = '0;
    cfg_one_shot = 1'b0;
    start        = '0;
    stop         = '0;
    sync_start   = 1'b0;
    now          = 0;
    model_reset();

    repeat (3) tick_edge();
    check("rst tick", 32'(tick), 0);
    check("rst busy", 32'(busy), 0);
    #3 reset_n = 1'b1;

    // default period on ch0
    start[0] = 1'b1;
    tick_edge();
    wait_tick(0, 200, n);
    check("ch0 first latency", n, DEFP);
    check("ch0 done low", 32'(done[0]), 0);
    wait_tick(0, 200, n);
    check("ch0 period", n, DEFP);
    check("ch0 busy", 32'(busy[0]), 1);
    stop[0] = 1'b1;
    tick_edge();

    // one-shot P=3 on ch1
    cfg_write(1, 3, 1'b1);
    start[1] = 1'b1;
    tick_edge();
    wait_tick(1, 20, n);
    check("ch1 oneshot latency", n, 3);
    check("ch1 done pulse", 32'(done[1]), 1);
    check("ch1 busy fell", 32'(busy[1]), 0);
    cnt0 = 0;
    for (int k = 0; k < 12; k++) begin
      tick_edge();
      if (tick[1]) cnt0++;
    end
    check("ch1 no retick", cnt0, 0);

    // mid-count period change on ch2
    cfg_write(2, 5, 1'b0);
    start[2] = 1'b1;
    tick_edge();
    cfg_we       = 1'b1;
    cfg_ch       = 3'd2;
    cfg_period   = 16'd2;
    cfg_one_shot = 1'b0;
    wait_tick(2, 20, n);
    check("ch2 old period", n, 5);
    wait_tick(2, 20, n);
    check("ch2 new period a", n, 2);
    wait_tick(2, 20, n);
    check("ch2 new period b", n, 2);
    stop[2] = 1'b1;
    tick_edge();

    // start+stop collisions on ch3, zero period on ch4
    cfg_write(3, 4, 1'b0);
    start[3] = 1'b1;
    stop[3]  = 1'b1;
    tick_edge();
    check("ch3 idle collide", 32'(busy[3]), 0);
    start[3] = 1'b1;
    tick_edge();
    tick_edge();
    start[3] = 1'b1;
    stop[3]  = 1'b1;
    tick_edge();
    check("ch3 run collide", 32'(busy[3]), 0);
    cnt3 = 0;
    for (int k = 0; k < 10; k++) begin
      tick_edge();
      if (tick[3]) cnt3++;
    end
    check("ch3 no tick", cnt3, 0);
    cfg_write(4, 0, 1'b0);
    start[4] = 1'b1;
    tick_edge();
    check("ch4 p0 ignored", 32'(busy[4]), 0);

    // sync start of P=1,2,4,8 plus an out-of-range write
    cfg_write(0, 1, 1'b0);
    cfg_write(1, 2, 1'b0);
    cfg_write(2, 4, 1'b0);
    cfg_write(3, 8, 1'b0);
    cfg_write(5, 3, 1'b0);
    sync_start = 1'b1;
    tick_edge();
    cnt0 = 0;
    cnt3 = 0;
    for (int k = 0; k < 8; k++) begin
      tick_edge();
      if (tick[0]) cnt0++;
      if (tick[3]) cnt3++;
    end
    check("sync ch0 every cycle", cnt0, 8);
    check("sync ch3 once", cnt3, 1);
    check("sync coincide", 32'(tick[3:0]), 32'hF);
    stop = '1;
    tick_edge();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        start[i] = ($urandom_range(0, 19) == 0);
        stop[i]  = ($urandom_range(0, 59) == 0);
      end
      sync_start = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) begin
        cfg_we       = 1'b1;
        cfg_ch       = CHW'($urandom_range(0, 7));
        cfg_period   = PW'($urandom_range(1, 12));
        cfg_one_shot = 1'($urandom_range(0, 1));
      end
      tick_edge();
    end
    stop = '1;
    tick_edge();

    // full-width period, then async reset mid-run
    cfg_write(0, 65535, 1'b0);
    start[0] = 1'b1;
    tick_edge();
    wait_tick(0, 70000, n);
    check("max period", n, 65535);
    repeat (300) tick_edge();
    #2 reset_n = 1'b0;
    #1;
    check("async tick", 32'(tick), 0);
    check("async busy", 32'(busy), 0);
    check("async done", 32'(done), 0);
    model_reset();
    tick_edge();
    #3 reset_n = 1'b1;
    cnt0 = 0;
    for (int k = 0; k < 200; k++) begin
      tick_edge();
      if (tick != '0) cnt0++;
    end
    check("idle after reset", cnt0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_pulse_gen.md
Name: tick_pulse_gen

Overview:
- Runtime-programmable, multi-channel tick generator; successor to the fixed compile-time timer-unit / baud period constants.
- Each channel emits one-cycle clock-enable ticks every P clocks, periodic or one-shot, with a glitch-free period update.
- Feeds timers, UART baud logic, PWM and on-chip-debug pacing from the single system clock.

Parameters:
- NUM_OF_CHANNELS, 4, number of independent tick channels (1..16)
- PERIOD_WIDTH, 16, bit width of each channel's period register
- DEFAULT_PERIOD, 96, reset period of every channel (96 MHz clock / 1 MHz classic timer unit)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- cfg_we  input  1  configuration write strobe
- cfg_ch  input  $clog2(NUM_OF_CHANNELS) (min 1)  channel selected for the write
- cfg_period  input  PERIOD_WIDTH  new period P
- cfg_one_shot  input  1  new mode: 0 = periodic, 1 = one-shot
- start  input  NUM_OF_CHANNELS  per-channel start/restart request, one-cycle pulse
- stop  input  NUM_OF_CHANNELS  per-channel stop request
- sync_start  input  1  start all channels on the same edge
- tick  output  NUM_OF_CHANNELS  one-cycle registered tick per channel
- busy  output  NUM_OF_CHANNELS  channel running
- done  output  NUM_OF_CHANNELS  one-cycle pulse on the final tick of a one-shot run

Behaviour:
- Single clock domain. Reset is asynchronous and active-low.
- Reset values: tick, busy and done are 0. Every counter is 0. Every shadow period is DEFAULT_PERIOD. Every mode is periodic.
- Per-channel state: shadow period, shadow mode, down-counter cnt (PERIOD_WIDTH), running flag. Channels are fully independent.
- Config write:
  - At a clk edge with cfg_we=1, the shadow period and mode of channel cfg_ch are updated.
  - If cfg_ch >= NUM_OF_CHANNELS, the write is ignored.
  - A running counter is never modified by a write. The new values take effect only at the next load or reload.
  - When a reload and a write fall on the same edge, the reload uses the old shadow value.
- Effective start = start[i] | sync_start.
- Start edge:
  - If the shadow period is 0, the start is ignored and the channel is not started.
  - Otherwise cnt <= P-1 and running <= 1.
  - A start while running restarts the channel: the counter is reloaded and no tick is emitted on that edge.
- Each edge while running and not starting:
  - If cnt != 0: cnt <= cnt-1 and tick <= 0.
  - If cnt == 0: tick <= 1.
    - Periodic mode: cnt <= P-1 from the shadow.
    - One-shot mode: running <= 0 and done <= 1 on the same edge.
- Latency: the first tick is asserted in the cycle following the edge that is P edges after the start edge.
  - Periodic ticks then repeat every P cycles.
  - P = 1 gives a tick every cycle.
- Mode sampling: the mode is sampled at each load or reload, like the period.
- Stop: at the edge where stop[i]=1, running <= 0 and tick/done <= 0. No tick is emitted on that edge.
- Simultaneous start and stop (including sync_start): stop wins.
- Outputs:
  - busy = running, registered.
  - busy falls on the same edge that done rises (one-shot) or on the stop edge.
  - tick, done and busy are registered outputs. There is no combinational path from any input to any output.
- Wrap-around: the maximum period 2^PERIOD_WIDTH-1 must count correctly. There is no overflow path, because the counter only decrements and reloads.
- Reset mid-run: all outputs fall immediately (asynchronous). After release the channel is idle until a new start.

Decomposition:
- Package tick_gen_pkg holds:
  - typedef enum logic {MODE_PERIODIC, MODE_ONE_SHOT} tick_mode_t
  - the DEFAULT_PERIOD constant
  - a period_t typedef sized by PERIOD_WIDTH
- Sub-module tick_channel holds one channel: shadow registers, counter, running flag, tick/done/busy flops.
- The top instantiates NUM_OF_CHANNELS copies in a generate loop and decodes cfg_ch into per-channel write enables.

Test Plan:
- Reset release, then start[0] with the default P=96 -> tick[0] high for 1 cycle at edge 96 after the start edge, and again every 96 cycles; busy[0]=1 throughout; done[0] stays 0.
- Write ch1 P=3, one-shot, then start[1] -> a single tick[1] 3 edges after start; done[1] pulses on the same cycle; busy[1] falls on that edge; no further ticks.
- Write ch2 P=5, start, then write P=2 mid-count -> the remaining ticks of the current period are at 5-cycle spacing; after the first reload, ticks are at 2-cycle spacing; no short or long glitch period.
- start[3] and stop[3] on the same edge while idle, and again while running with P=4 -> the channel ends idle with busy[3]=0 and no tick in either case; start on a channel with P=0 -> ignored, busy stays 0.
- Channels configured to P=1, 2, 4, 8, then sync_start -> all ticks coincide at edge 8; ch0 ticks every cycle; a write with cfg_ch=5 (out of range) has no effect.
- Assert reset_n=0 asynchronously mid-period on a P=65535 run -> tick, busy and done drop immediately; after release, no tick occurs until a new start; the full 65535-cycle period is verified once.
